// File: rtl/mem_ctrl_pkg.sv
// Types and widths shared by the memory request front-end
// and the SDRAM-style controller it feeds.
package mem_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 12;

  typedef enum logic [2:0] {
    CMD_NOP            = 3'b000,
    CMD_ACTIVE         = 3'b001,
    CMD_READ           = 3'b010,
    CMD_WRITE          = 3'b011,
    CMD_PRECHARGE      = 3'b100,
    CMD_REFRESH        = 3'b101,
    CMD_LOAD_MODE      = 3'b110,
    CMD_REF_OR_ACT_RNW = 3'b111
  } cmd_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_req_sequencer_if.sv
// Host request/response bundle and controller command bundle.
// master drives the request side of each link.
interface mem_req_if;
  import mem_ctrl_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_wr;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata
  );
endinterface

interface mc_cmd_if;
  import mem_ctrl_pkg::*;
  logic              mc_cmd_n;
  logic              mc_rdnwr;
  logic [ADDR_W-1:0] mc_addr;
  logic              mc_data_in_vld;
  logic [DATA_W-1:0] mc_data_in;
  cmd_t              mc_command;
  logic [DATA_W-1:0] mc_data_out;

  modport master (
    output mc_cmd_n, mc_rdnwr, mc_addr, mc_data_in_vld, mc_data_in,
    input  mc_command, mc_data_out
  );
  modport slave (
    input  mc_cmd_n, mc_rdnwr, mc_addr, mc_data_in_vld, mc_data_in,
    output mc_command, mc_data_out
  );
endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; a push while full is taken
// only when a pop frees the head slot in the same cycle.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  mem_req_t               i_data,
  input  logic                   i_pop,
  output mem_req_t               o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  mem_req_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != L_FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == L_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/mem_req_sequencer.sv
// Queues host requests and issues them one at a time to the
// memory controller, returning one-cycle completions.
module mem_req_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_req_if.slave host,
  mc_cmd_if.master mc,
  output logic     busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [7:0] L_TO    = 8'(TIMEOUT);
  localparam logic [2:0] L_LAT   = 3'(RD_LAT);
  localparam int         CW      = $clog2(DEPTH) + 1;

  logic [1:0]        r_state;
  logic              r_wr;
  logic [7:0]        r_to_cnt;
  logic [2:0]        r_lat_cnt;
  logic              r_cmd_n;
  logic              r_rdnwr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_data_vld;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_wr;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rdata;

  mem_req_t          w_req;
  mem_req_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_pop;
  logic              w_wr_ack;
  logic              w_rd_ack;
  logic [7:0]        w_to_nxt;
  logic              w_to_hit;

  assign w_req.wr    = host.req_wr;
  assign w_req.addr  = host.req_addr;
  assign w_req.wdata = host.req_wdata;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (host.req_valid && host.req_ready),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Acks only count when they match the direction in flight.
  assign w_wr_ack = r_wr && (mc.mc_command == CMD_WRITE);
  assign w_rd_ack = !r_wr && (mc.mc_command == CMD_READ);
  assign w_to_nxt = (r_to_cnt == 8'hFF) ? r_to_cnt
                                        : r_to_cnt + 8'd1;
  assign w_to_hit = (w_to_nxt == L_TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_to_cnt    <= '0;
      r_lat_cnt   <= '0;
      r_cmd_n     <= 1'b1;
      r_rdnwr     <= 1'b0;
      r_addr      <= '0;
      r_data_vld  <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_wr    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state  <= S_ISSUE;
            r_wr     <= w_head.wr;
            r_to_cnt <= '0;
            r_cmd_n  <= 1'b0;
            r_rdnwr  <= !w_head.wr;
            r_addr   <= w_head.addr;
            if (w_head.wr) begin
              r_wdata    <= w_head.wdata;
              r_data_vld <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Ack has priority over a timeout in the same cycle.
          priority case (1'b1)
            w_wr_ack: begin
              r_state     <= S_RESP;
              r_cmd_n     <= 1'b1;
              r_data_vld  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_wr    <= 1'b1;
              r_rsp_err   <= 1'b0;
            end
            w_rd_ack: begin
              r_state    <= S_WAIT;
              r_cmd_n    <= 1'b1;
              r_lat_cnt  <= L_LAT;
            end
            w_to_hit: begin
              r_state     <= S_RESP;
              r_to_cnt    <= w_to_nxt;
              r_cmd_n     <= 1'b1;
              r_data_vld  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_wr    <= r_wr;
              r_rsp_err   <= 1'b1;
            end
            default: r_to_cnt <= w_to_nxt;
          endcase
        end
        S_WAIT: begin
          if (r_lat_cnt <= 3'd1) begin
            r_state     <= S_RESP;
            r_rdata     <= mc.mc_data_out;
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b0;
            r_rsp_err   <= 1'b0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host.req_ready  = !w_full;
  assign host.rsp_valid  = r_rsp_valid;
  assign host.rsp_wr     = r_rsp_wr;
  assign host.rsp_err    = r_rsp_err;
  assign host.rsp_rdata  = r_rdata;
  assign mc.mc_cmd_n       = r_cmd_n;
  assign mc.mc_rdnwr       = r_rdnwr;
  assign mc.mc_addr        = r_addr;
  assign mc.mc_data_in_vld = r_data_vld;
  assign mc.mc_data_in     = r_wdata;
  assign busy = (r_state != S_IDLE) || (w_count != '0);
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Scoreboard bench: a host driver, a controller model that
// acks per request plan, and a response monitor.
module tb_mem_req_sequencer;
  import mem_ctrl_pkg::*;

  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_req_if host();
  mc_cmd_if  mc();

  mem_req_sequencer #(
    .DEPTH(4), .RD_LAT(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host(host), .mc(mc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  // lo: ISSUE cycles before the ack (0 = never ack)
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lo;
    bit          rf;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  exp_t  m_e;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_req_ready"}, host.req_ready, 1);
    check({t, "_rsp"},
          {host.rsp_valid, host.rsp_wr, host.rsp_err}, 0);
    check({t, "_rdata"}, host.rsp_rdata, 0);
    check({t, "_cmd_n"}, mc.mc_cmd_n, 1);
    check({t, "_mc"},
          {mc.mc_rdnwr, mc.mc_data_in_vld, mc.mc_addr}, 0);
    check({t, "_data_in"}, mc.mc_data_in, 0);
    check({t, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && host.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        m_e = exp_q.pop_front();
        check("rsp_wr", host.rsp_wr, m_e.wr);
        check("rsp_err", host.rsp_err, m_e.err);
        if (!m_e.wr && !m_e.err)
          check("rsp_rdata", host.rsp_rdata, m_e.rdata);
      end
    end
  end

  task automatic serve(input plan_t p);
    logic [15:0] a;
    logic [31:0] d;
    logic        rn;
    logic        v;
    bit          stable;
    int          k;
    rn = mc.mc_rdnwr;
    a  = mc.mc_addr;
    v  = mc.mc_data_in_vld;
    d  = mc.mc_data_in;
    check("mc_rdnwr", rn, !p.wr);
    check("mc_addr", a, p.addr);
    check("mc_data_in_vld", v, p.wr);
    if (p.wr) check("mc_data_in", d, p.wdata);
    stable = 1'b1;
    k = 0;
    while (mc.mc_cmd_n == 1'b0 && k < 400) begin
      if (mc.mc_rdnwr !== rn || mc.mc_addr !== a ||
          mc.mc_data_in_vld !== v || mc.mc_data_in !== d)
        stable = 1'b0;
      if (p.lo != 0 && k == p.lo - 1)
        mc.mc_command = p.wr ? CMD_WRITE : CMD_READ;
      else if (p.rf)
        mc.mc_command = k[0] ? CMD_REF_OR_ACT_RNW
                             : CMD_REFRESH;
      else
        mc.mc_command = CMD_NOP;
      @(negedge clk);
      k++;
    end
    mc.mc_command = CMD_NOP;
    check("mc_stable", stable, 1);
    check("issue_cycles", k, (p.lo != 0) ? p.lo : TO);
    if (!p.wr && p.lo != 0) begin
      mc.mc_data_out = p.rdata;
      @(negedge clk);
      mc.mc_data_out = 32'hA5A5_5A5A;
    end
  endtask

  initial begin : model
    mc.mc_command  = CMD_NOP;
    mc.mc_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mc.mc_cmd_n == 1'b0 && plan_q.size() != 0)
        serve(plan_q.pop_front());
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic send(input logic wr, input logic [15:0] a,
                      input logic [31:0] d, input int lo,
                      input bit rf, input logic [31:0] rd);
    plan_t p;
    exp_t  e;
    int    n;
    host.req_valid = 1'b1;
    host.req_wr    = wr;
    host.req_addr  = a;
    host.req_wdata = d;
    n = 0;
    while (!host.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!host.req_ready) begin
      check("req_ready_wait", 0, 1);
      host.req_valid = 1'b0;
      return;
    end
    p.wr = wr; p.addr = a; p.wdata = d;
    p.lo = lo; p.rf = rf; p.rdata = rd;
    plan_q.push_back(p);
    e.wr = wr; e.err = (lo == 0); e.rdata = rd;
    exp_q.push_back(e);
    @(negedge clk);
    host.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, (exp_q.size() != 0) || busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks",
             errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    int n;
    bit prev_low;
    host.req_valid = 1'b0;
    host.req_wr    = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send(1, 16'h1234, 32'hDEAD_BEEF, 5, 0, 0);
    drain("t1_drain");

    send(0, 16'h1234, 0, 6, 0, 32'hDEAD_BEEF);
    drain("t2_drain");

    send(1, 16'h0001, 32'h1111_0001, 8, 0, 0);
    send(0, 16'h1002, 0, 8, 0, 32'h2222_0002);
    send(1, 16'h2003, 32'h3333_0003, 8, 0, 0);
    send(0, 16'h3004, 0, 8, 0, 32'h4444_0004);
    send(1, 16'h4005, 32'h5555_0005, 8, 0, 0);
    check("t3_full_ready", host.req_ready, 0);
    check("t3_busy", busy, 1);
    drain("t3_drain");

    send(1, 16'hBEEF, 32'hCAFE_F00D, 0, 0, 0);
    send(0, 16'h0BAD, 0, 3, 0, 32'h1357_9BDF);
    drain("t4_drain");

    send(0, 16'h5A5A, 0, 41, 1, 32'h0F0F_F0F0);
    drain("t5_drain");

    send(0, 16'h6006, 0, 3, 0, 32'h6666_6666);
    send(1, 16'h7007, 32'h7777_7777, 3, 0, 0);
    send(1, 16'h8008, 32'h8888_8888, 3, 0, 0);
    n = 0;
    prev_low = 1'b0;
    while (!(prev_low && mc.mc_cmd_n) && n < 100) begin
      prev_low = !mc.mc_cmd_n;
      @(negedge clk);
      n++;
    end
    check("t6_reach_wait", n < 100, 1);
    rst_n = 1'b0;
    exp_q.delete();
    plan_q.delete();
    #1;
    check_reset("t6_async");
    repeat (2) @(negedge clk);
    check_reset("t6_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_rsp", host.rsp_valid, 0);
    check("t6_idle", busy, 0);
    send(1, 16'h9009, 32'h9999_9999, 2, 0, 0);
    drain("t6_recover");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
